// File: rtl/vram_blit_if.sv
// vram_blit_if: control and VRAM-port signals of the blit engine.
// master = the engine; slave = the host/arbiter/VRAM side.
interface vram_blit_if #(
  parameter int COUNT_W = 16
);
  logic               start;
  logic               mode_copy;
  logic [15:0]        src_addr;
  logic [15:0]        dst_addr;
  logic [COUNT_W-1:0] count;
  logic [15:0]        fill_value;
  logic               dir_down;
  logic               grant;
  logic               vram_req;
  logic               vram_sel;
  logic               vram_wr_en;
  logic [15:0]        vram_addr;
  logic [15:0]        vram_wdata;
  logic [15:0]        vram_rdata;
  logic               busy;
  logic               done;

  modport master (
    input  start, mode_copy, src_addr, dst_addr, count, fill_value, dir_down,
           grant, vram_rdata,
    output vram_req, vram_sel, vram_wr_en, vram_addr, vram_wdata, busy, done
  );

  modport slave (
    output start, mode_copy, src_addr, dst_addr, count, fill_value, dir_down,
           grant, vram_rdata,
    input  vram_req, vram_sel, vram_wr_en, vram_addr, vram_wdata, busy, done
  );
endinterface

// File: rtl/vram_blit.sv
// vram_blit: VRAM block fill / block copy initiator behind the VRAM arbiter.
// Copy is READ -> CAPTURE -> WRITE per word (3 cycles/word); fill writes
// 1 word/cycle under continuous grant.
// Optional macro VRAM_BLIT_DECR_EN: dir_down (sampled at start) selects a
// -1 address step for src and dst; without it the step is always +1.
module vram_blit #(
  parameter int COUNT_W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  vram_blit_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        src_q, src_d;
  logic [15:0]        dst_q, dst_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [15:0]        fill_q, fill_d;
  logic [15:0]        hold_q, hold_d;
  logic               copy_q, copy_d;
  logic [15:0]        step;

`ifdef VRAM_BLIT_DECR_EN
  logic               dir_q, dir_d;
  // All-ones is -1 modulo 2^16, so FFFF steps 0000 -> FFFF.
  assign step = dir_q ? 16'hFFFF : 16'h0001;
`else
  assign step = 16'h0001;
`endif

  // State and datapath registers; reset aborts any operation without done.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      copy_q  <= 1'b0;
`ifdef VRAM_BLIT_DECR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      copy_q  <= copy_d;
`ifdef VRAM_BLIT_DECR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  // Next-state and VRAM port drive; address/data come straight from
  // registers so they are stable across ungranted cycles.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    rem_d          = rem_q;
    fill_d         = fill_q;
    hold_d         = hold_q;
    copy_d         = copy_q;
`ifdef VRAM_BLIT_DECR_EN
    dir_d          = dir_q;
`endif
    bus.vram_req   = 1'b0;
    bus.vram_wr_en = 1'b0;
    bus.vram_addr  = '0;
    bus.vram_wdata = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          src_d  = bus.src_addr;
          dst_d  = bus.dst_addr;
          rem_d  = bus.count;
          fill_d = bus.fill_value;
          copy_d = bus.mode_copy;
`ifdef VRAM_BLIT_DECR_EN
          dir_d  = bus.dir_down;
`endif
          if (bus.count == '0)   state_d = S_FINISH;
          else if (bus.mode_copy) state_d = S_READ;
          else                    state_d = S_WRITE;
        end
      end
      S_READ: begin
        bus.busy      = 1'b1;
        bus.vram_req  = 1'b1;
        bus.vram_addr = src_q;
        if (bus.grant) begin
          src_d   = src_q + step;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // Read data is valid exactly this cycle; no grant required.
        bus.busy = 1'b1;
        hold_d   = bus.vram_rdata;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        bus.busy       = 1'b1;
        bus.vram_req   = 1'b1;
        bus.vram_wr_en = 1'b1;
        bus.vram_addr  = dst_q;
        bus.vram_wdata = copy_q ? hold_q : fill_q;
        if (bus.grant) begin
          dst_d = dst_q + step;
          rem_d = rem_q - 1'b1;
          if (rem_q == COUNT_W'(1)) state_d = S_FINISH;
          else if (copy_q)          state_d = S_READ;
        end
      end
      S_FINISH: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.vram_sel = bus.vram_req & bus.grant;

endmodule
